// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and IF/ID capture with stall, redirect flush and halt sequencing
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stall,
    input  logic             i_br_taken,
    input  logic [31:0]      i_br_target,
    input  logic             i_jmp,
    input  logic [31:0]      i_jmp_target,
    input  logic             i_halt,
    input  logic [31:0]      i_inst,
    output logic [31:0]      o_addr,
    output logic [31:0]      o_ifid_inst,
    output logic [31:0]      o_ifid_pc4,
    output logic             o_ifid_valid,
    output logic             o_running,
    output logic [CNT_W-1:0] o_fetch_cnt
);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]       r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_ifid_inst;
    logic [31:0]      r_ifid_pc4;
    logic             r_ifid_valid;
    logic [CNT_W-1:0] r_fetch_cnt;

    logic [31:0]      w_pc4;
    logic             w_redirect;
    logic [31:0]      w_target;

    assign w_pc4      = r_pc + 32'd4;
    assign w_redirect = i_br_taken | i_jmp;
    // Branch outranks jump; targets are forced word aligned on load.
    assign w_target   = i_br_taken ? {i_br_target[31:2], 2'b00} : {i_jmp_target[31:2], 2'b00};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_BOOT;
            r_pc         <= RESET_PC;
            r_ifid_inst  <= 32'd0;
            r_ifid_pc4   <= 32'd0;
            r_ifid_valid <= 1'b0;
            r_fetch_cnt  <= '0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_state <= S_RUN;
                end
                S_RUN, S_FLUSH: begin
                    // A stall in FLUSH leaves the bubble in place; the target word is captured from RUN.
                    if (i_stall) begin
                        r_state <= S_RUN;
                    end else if (w_redirect) begin
                        r_pc         <= w_target;
                        r_ifid_valid <= 1'b0;
                        r_state      <= S_FLUSH;
                    end else if (i_halt) begin
                        r_ifid_valid <= 1'b0;
                        r_state      <= S_HOLD;
                    end else begin
                        r_ifid_inst  <= i_inst;
                        r_ifid_pc4   <= w_pc4;
                        r_ifid_valid <= 1'b1;
                        r_pc         <= w_pc4;
                        if (r_fetch_cnt != {CNT_W{1'b1}}) begin
                            r_fetch_cnt <= r_fetch_cnt + 1'b1;
                        end
                        r_state      <= S_RUN;
                    end
                end
                default: begin
                    r_ifid_valid <= 1'b0;
                    if (!i_halt) begin
                        r_state <= S_RUN;
                    end
                end
            endcase
        end
    end

    assign o_addr       = r_pc;
    assign o_ifid_inst  = r_ifid_inst;
    assign o_ifid_pc4   = r_ifid_pc4;
    assign o_ifid_valid = r_ifid_valid;
    assign o_running    = (r_state == S_RUN) || (r_state == S_FLUSH);
    assign o_fetch_cnt  = r_fetch_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed bench for fetch_sequencer, plus a narrow-counter copy for saturation
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, br_taken, jmp, halt;
    logic [31:0] br_target, jmp_target;

    logic [31:0] inst_m, addr_m, ifid_inst_m, ifid_pc4_m;
    logic        ifid_valid_m, running_m;
    logic [15:0] cnt_m;

    logic [31:0] inst_s, addr_s, ifid_inst_s, ifid_pc4_s;
    logic        ifid_valid_s, running_s;
    logic [2:0]  cnt_s;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h5A00_0000 ^ a;
    endfunction

    assign inst_m = rom(addr_m);
    assign inst_s = rom(addr_s);

    fetch_sequencer #(.RESET_PC(32'h0), .CNT_W(16)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_br_taken(br_taken),
        .i_br_target(br_target), .i_jmp(jmp), .i_jmp_target(jmp_target),
        .i_halt(halt), .i_inst(inst_m), .o_addr(addr_m), .o_ifid_inst(ifid_inst_m),
        .o_ifid_pc4(ifid_pc4_m), .o_ifid_valid(ifid_valid_m), .o_running(running_m),
        .o_fetch_cnt(cnt_m)
    );

    fetch_sequencer #(.RESET_PC(32'h0), .CNT_W(3)) u_dut_sat (
        .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_br_taken(br_taken),
        .i_br_target(br_target), .i_jmp(jmp), .i_jmp_target(jmp_target),
        .i_halt(halt), .i_inst(inst_s), .o_addr(addr_s), .o_ifid_inst(ifid_inst_s),
        .o_ifid_pc4(ifid_pc4_s), .o_ifid_valid(ifid_valid_s), .o_running(running_s),
        .o_fetch_cnt(cnt_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_capture(input string tag, input logic [31:0] pc, input logic [15:0] cnt);
        chk({tag, "_inst"},  ifid_inst_m, rom(pc));
        chk({tag, "_pc4"},   ifid_pc4_m, pc + 32'd4);
        chk({tag, "_valid"}, {31'd0, ifid_valid_m}, 32'd1);
        chk({tag, "_cnt"},   {16'd0, cnt_m}, {16'd0, cnt});
        chk({tag, "_sat"},   {29'd0, cnt_s}, (cnt > 16'd7) ? 32'd7 : {16'd0, cnt});
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; br_taken = 1'b0; jmp = 1'b0; halt = 1'b0;
        br_target = 32'h0; jmp_target = 32'h0;
        step();
        chk("rst_addr",    addr_m, 32'h0);
        chk("rst_valid",   {31'd0, ifid_valid_m}, 32'd0);
        chk("rst_cnt",     {16'd0, cnt_m}, 32'd0);
        chk("rst_running", {31'd0, running_m}, 32'd0);

        rst = 1'b0;
        #2;
        chk("boot_addr",    addr_m, 32'h0);
        chk("boot_valid",   {31'd0, ifid_valid_m}, 32'd0);
        chk("boot_running", {31'd0, running_m}, 32'd0);
        step();
        chk("run_running", {31'd0, running_m}, 32'd1);
        chk("run_valid",   {31'd0, ifid_valid_m}, 32'd0);

        for (int k = 1; k <= 3; k++) begin
            step();
            chk_capture("adv", 32'(4 * (k - 1)), 16'(k));
        end
        chk("pre_stall_addr", addr_m, 32'h0C);

        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_addr", addr_m, 32'h0C);
            chk_capture("stall", 32'h08, 16'd3);
        end
        stall = 1'b0;
        step();
        chk_capture("unstall", 32'h0C, 16'd4);
        step();
        chk_capture("adv5", 32'h10, 16'd5);
        chk("adv5_addr", addr_m, 32'h14);

        for (int k = 6; k <= 8; k++) step();
        chk_capture("adv8", 32'h1C, 16'd8);
        chk("pre_br_addr", addr_m, 32'h20);

        br_taken = 1'b1; br_target = 32'h30; stall = 1'b1;
        step();
        chk("br_stall_addr", addr_m, 32'h20);
        chk_capture("br_stall", 32'h1C, 16'd8);
        stall = 1'b0;
        step();
        br_taken = 1'b0;
        chk("br_addr",    addr_m, 32'h30);
        chk("br_bubble",  {31'd0, ifid_valid_m}, 32'd0);
        chk("br_running", {31'd0, running_m}, 32'd1);
        step();
        chk_capture("br_tgt", 32'h30, 16'd9);

        br_taken = 1'b1; br_target = 32'h40; jmp = 1'b1; jmp_target = 32'h0;
        step();
        br_taken = 1'b0; jmp = 1'b0;
        chk("both_addr",   addr_m, 32'h40);
        chk("both_bubble", {31'd0, ifid_valid_m}, 32'd0);
        step();
        chk_capture("both_tgt", 32'h40, 16'd10);

        jmp = 1'b1; jmp_target = 32'h13;
        step();
        jmp = 1'b0;
        chk("jmp_align_addr", addr_m, 32'h10);
        step();
        chk_capture("jmp_tgt", 32'h10, 16'd11);
        step();
        chk("pre_halt_addr", addr_m, 32'h18);

        halt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("halt_running", {31'd0, running_m}, 32'd0);
            chk("halt_valid",   {31'd0, ifid_valid_m}, 32'd0);
            chk("halt_addr",    addr_m, 32'h18);
            chk("halt_cnt",     {16'd0, cnt_m}, 32'd12);
        end
        halt = 1'b0;
        step();
        chk("resume_running", {31'd0, running_m}, 32'd1);
        chk("resume_addr",    addr_m, 32'h18);
        step();
        chk_capture("resume", 32'h18, 16'd13);

        jmp = 1'b1; jmp_target = 32'hFFFF_FFFC;
        step();
        jmp = 1'b0;
        chk("wrap_addr0", addr_m, 32'hFFFF_FFFC);
        step();
        chk("wrap_pc4",  ifid_pc4_m, 32'h0);
        chk("wrap_addr", addr_m, 32'h0);
        chk("wrap_cnt",  {16'd0, cnt_m}, 32'd14);

        jmp = 1'b1; jmp_target = 32'h100;
        step();
        jmp = 1'b0;
        chk("flush_addr",    addr_m, 32'h100);
        chk("flush_running", {31'd0, running_m}, 32'd1);
        chk("flush_sat",     {29'd0, cnt_s}, 32'd7);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_addr",    addr_m, 32'h0);
        chk("arst_inst",    ifid_inst_m, 32'h0);
        chk("arst_pc4",     ifid_pc4_m, 32'h0);
        chk("arst_valid",   {31'd0, ifid_valid_m}, 32'd0);
        chk("arst_running", {31'd0, running_m}, 32'd0);
        chk("arst_cnt",     {16'd0, cnt_m}, 32'd0);
        chk("arst_sat_cnt", {29'd0, cnt_s}, 32'd0);
        chk("arst_sat_run", {31'd0, running_s}, 32'd0);
        chk("arst_sat_addr", addr_s, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
